// File: rtl/count_step_decoder_pkg.sv
// Shared types for the counter step decoder: FSM states, delta classes and
// small helpers that map a step class onto the counter's UpDown/Inc encoding.
package count_step_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    TRACK
  } state_t;

  typedef enum logic [2:0] {
    UP1,
    UP2,
    DN1,
    DN2,
    HOLD,
    INVALID
  } delta_class_t;

  function automatic logic is_step(input delta_class_t c);
    return (c == UP1) || (c == UP2) || (c == DN1) || (c == DN2);
  endfunction

  // UpDown encoding: 0 = up, 1 = down
  function automatic logic class_dir(input delta_class_t c);
    return (c == DN1) || (c == DN2);
  endfunction

  // Inc encoding: 0 = step of 1, 1 = step of 2
  function automatic logic class_inc(input delta_class_t c);
    return (c == UP2) || (c == DN2);
  endfunction

endpackage

// File: rtl/count_step_decoder_if.sv
// Sample/result bundle between the counter datapath and the step decoder.
interface count_step_decoder_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             sample_en;
  logic [N-1:0]     count;
  logic             up_down;
  logic             inc;
  logic             step_valid;
  logic             hold;
  logic             err;
  logic             locked;
  logic [CNT_W-1:0] err_count;

  modport master (
    output sample_en, count,
    input  up_down, inc, step_valid, hold, err, locked, err_count
  );

  modport slave (
    input  sample_en, count,
    output up_down, inc, step_valid, hold, err, locked, err_count
  );
endinterface

// File: rtl/count_step_decoder_classify.sv
// Combinational classifier: modular delta between the new and previous count
// mapped onto the +1/+2/-1/-2/hold/invalid step classes.
module count_delta_classify
  import count_step_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] count,
  input  logic [N-1:0] prev,
  output delta_class_t cls
);

  localparam logic [N-1:0] D_UP1 = N'(1);
  localparam logic [N-1:0] D_UP2 = N'(2);
  localparam logic [N-1:0] D_DN1 = {N{1'b1}};
  localparam logic [N-1:0] D_DN2 = {{(N-1){1'b1}}, 1'b0};

  logic [N-1:0] delta;

  // Wrap-around falls out of the N-bit subtraction.
  assign delta = count - prev;

  always_comb begin
    cls = INVALID;
    if (delta == D_UP1)      cls = UP1;
    else if (delta == D_UP2) cls = UP2;
    else if (delta == D_DN1) cls = DN1;
    else if (delta == D_DN2) cls = DN2;
    else if (delta == '0)    cls = HOLD;
  end

endmodule

// File: rtl/count_step_decoder.sv
// Recovers UpDown/Inc step commands from a sampled wrap-around counter,
// flags protocol violations and tracks lock.
module count_step_decoder
  import count_step_pkg::*;
#(
  parameter int N         = 4,
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W     = 8
) (
  input logic                clk,
  input logic                reset,
  count_step_decoder_if.slave bus
);

  if (N < 3) begin : g_bad_n
    $error("count_step_decoder: N must be >= 3");
  end
  if (ERR_LIMIT < 1) begin : g_bad_limit
    $error("count_step_decoder: ERR_LIMIT must be >= 1");
  end

  localparam int RUN_W = $clog2(ERR_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(ERR_LIMIT - 1);

  state_t           state;
  logic [N-1:0]     prev;
  logic [RUN_W-1:0] err_run;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] err_count_nxt;
  logic             ud_q, inc_q, sv_q, hold_q, err_q, locked_q;
  delta_class_t     cls;

  count_delta_classify #(.N(N)) u_classify (
    .count (bus.count),
    .prev  (prev),
    .cls   (cls)
  );

  assign err_count_nxt = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prev        <= '0;
      err_run     <= '0;
      err_count_q <= '0;
      ud_q        <= 1'b0;
      inc_q       <= 1'b0;
      sv_q        <= 1'b0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      sv_q   <= 1'b0;
      hold_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.sample_en) begin
        prev <= bus.count;
        unique case (state)
          IDLE: state <= ACQ;
          // ACQ and TRACK share step/hold handling; only the error run differs.
          ACQ, TRACK: begin
            if (is_step(cls)) begin
              sv_q     <= 1'b1;
              ud_q     <= class_dir(cls);
              inc_q    <= class_inc(cls);
              err_run  <= '0;
              state    <= TRACK;
              locked_q <= 1'b1;
            end else if (cls == HOLD) begin
              hold_q <= 1'b1;
            end else begin
              err_q       <= 1'b1;
              err_count_q <= err_count_nxt;
              if (state == TRACK) begin
                if (err_run == RUN_LAST) begin
                  err_run  <= '0;
                  state    <= ACQ;
                  locked_q <= 1'b0;
                end else begin
                  err_run <= err_run + 1'b1;
                end
              end
            end
          end
          default: begin
            state    <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.up_down    = ud_q;
  assign bus.inc        = inc_q;
  assign bus.step_valid = sv_q;
  assign bus.hold       = hold_q;
  assign bus.err        = err_q;
  assign bus.locked     = locked_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_count_step_decoder.sv
// Bench for count_step_decoder: two instances (default and CNT_W=2/ERR_LIMIT=1)
// driven by the same stimulus and checked against a behavioural model.
module tb_count_step_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] cnt;
  int         checks;
  int         errors;
  bit         chk_on;

  count_step_decoder_if #(.N(4), .CNT_W(8)) ifa ();
  count_step_decoder_if #(.N(4), .CNT_W(2)) ifb ();

  assign ifa.sample_en = en;
  assign ifa.count     = cnt;
  assign ifb.sample_en = en;
  assign ifb.count     = cnt;

  count_step_decoder #(.N(4), .ERR_LIMIT(3), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifa)
  );

  count_step_decoder #(.N(4), .ERR_LIMIT(1), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit have;
    bit lk;
    int prev;
    int run;
    int errs;
    bit ud;
    bit inc;
    bit sv;
    bit hd;
    bit er;
  } mstate_t;

  mstate_t m_a = '{default: 0};
  mstate_t m_b = '{default: 0};

  function automatic mstate_t mnext(input mstate_t s, input bit e, input int c,
                                    input int limit, input int emax);
    mstate_t n = s;
    int d;
    n.sv = 0;
    n.hd = 0;
    n.er = 0;
    if (!e) return n;
    if (!s.have) begin
      n.have = 1;
      n.prev = c;
      return n;
    end
    d = ((c - s.prev) % 16 + 16) % 16;
    n.prev = c;
    if (d == 1 || d == 2 || d == 15 || d == 14) begin
      n.sv  = 1;
      n.ud  = (d >= 14);
      n.inc = (d == 2 || d == 14);
      n.run = 0;
      n.lk  = 1;
    end else if (d == 0) begin
      n.hd = 1;
    end else begin
      n.er   = 1;
      n.errs = (s.errs + 1 > emax) ? emax : s.errs + 1;
      if (s.lk) begin
        n.run = s.run + 1;
        if (n.run >= limit) begin
          n.lk  = 0;
          n.run = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '{default: 0};
      m_b <= '{default: 0};
    end else begin
      m_a <= mnext(m_a, en, int'(cnt), 3, 255);
      m_b <= mnext(m_b, en, int'(cnt), 1, 3);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a.up_down",    32'(ifa.up_down),    32'(m_a.ud));
      chk("a.inc",        32'(ifa.inc),        32'(m_a.inc));
      chk("a.step_valid", 32'(ifa.step_valid), 32'(m_a.sv));
      chk("a.hold",       32'(ifa.hold),       32'(m_a.hd));
      chk("a.err",        32'(ifa.err),        32'(m_a.er));
      chk("a.locked",     32'(ifa.locked),     32'(m_a.lk));
      chk("a.err_count",  32'(ifa.err_count),  32'(m_a.errs));
      chk("b.up_down",    32'(ifb.up_down),    32'(m_b.ud));
      chk("b.inc",        32'(ifb.inc),        32'(m_b.inc));
      chk("b.step_valid", 32'(ifb.step_valid), 32'(m_b.sv));
      chk("b.hold",       32'(ifb.hold),       32'(m_b.hd));
      chk("b.err",        32'(ifb.err),        32'(m_b.er));
      chk("b.locked",     32'(ifb.locked),     32'(m_b.lk));
      chk("b.err_count",  32'(ifb.err_count),  32'(m_b.errs));
    end
  end

  task automatic step(input bit e, input int c);
    en  = e;
    cnt = c[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input bit sv, input bit ud, input bit inc,
                          input bit hd, input bit er, input bit lk);
    chk({tag, ".step_valid"}, 32'(ifa.step_valid), 32'(sv));
    chk({tag, ".up_down"},    32'(ifa.up_down),    32'(ud));
    chk({tag, ".inc"},        32'(ifa.inc),        32'(inc));
    chk({tag, ".hold"},       32'(ifa.hold),       32'(hd));
    chk({tag, ".err"},        32'(ifa.err),        32'(er));
    chk({tag, ".locked"},     32'(ifa.locked),     32'(lk));
  endtask

  initial begin
    int c;
    int r;
    checks = 0;
    errors = 0;
    chk_on = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    cnt    = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_a("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.err_count", 32'(ifa.err_count), 32'd0);
    rst_n  = 1'b1;
    chk_on = 1;

    // 1: first sample silent, then up-by-one steps lock
    step(1, 0);  expect_a("t1.first", 0, 0, 0, 0, 0, 0);
    step(1, 1);  expect_a("t1.s1", 1, 0, 0, 0, 0, 1);
    step(1, 2);  expect_a("t1.s2", 1, 0, 0, 0, 0, 1);
    step(1, 3);  expect_a("t1.s3", 1, 0, 0, 0, 0, 1);

    // 2: wrap-around steps in both directions
    step(1, 5);  expect_a("t2.up2", 1, 0, 1, 0, 0, 1);
    step(1, 7);
    step(1, 9);
    step(1, 11);
    step(1, 13);
    step(1, 14); expect_a("t2.up1", 1, 0, 0, 0, 0, 1);
    step(1, 0);  expect_a("t2.14to0", 1, 0, 1, 0, 0, 1);
    step(1, 15); expect_a("t2.0to15", 1, 1, 0, 0, 0, 1);
    step(1, 13); expect_a("t2.15to13", 1, 1, 1, 0, 0, 1);

    // 3: three invalid deltas drop lock, a valid step restores it
    step(1, 15);
    step(1, 1);
    step(1, 5);  expect_a("t3.e1", 0, 0, 1, 0, 1, 1);
    step(1, 9);  expect_a("t3.e2", 0, 0, 1, 0, 1, 1);
    step(1, 13); expect_a("t3.e3", 0, 0, 1, 0, 1, 0);
    chk("t3.err_count", 32'(ifa.err_count), 32'd3);
    step(1, 14); expect_a("t3.relock", 1, 0, 0, 0, 0, 1);

    // 4: hold, then disabled sampling, then resume
    step(1, 0);
    step(1, 2);
    step(1, 4);
    step(1, 6);
    step(1, 7);
    step(1, 7);  expect_a("t4.hold", 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 12); expect_a("t4.off", 0, 0, 0, 0, 0, 1);
    end
    step(1, 8);  expect_a("t4.resume", 1, 0, 0, 0, 0, 1);

    // 5: asynchronous reset while locked
    step(1, 6);
    #1 rst_n = 1'b0;
    #1;
    chk("t5.locked",    32'(ifa.locked),    32'd0);
    chk("t5.up_down",   32'(ifa.up_down),   32'd0);
    chk("t5.inc",       32'(ifa.inc),       32'd0);
    chk("t5.err_count", 32'(ifa.err_count), 32'd0);
    #1 rst_n = 1'b1;
    step(1, 5);  expect_a("t5.first", 0, 0, 0, 0, 0, 0);
    step(1, 6);  expect_a("t5.step", 1, 0, 0, 0, 0, 1);

    // randomized traffic, mostly legal steps with occasional faults and resets
    c = 6;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 7: c = c + 1;
        2:       c = c + 2;
        3, 8:    c = c - 1;
        4:       c = c - 2;
        5:       c = c;
        default: c = int'($urandom_range(0, 15));
      endcase
      c = ((c % 16) + 16) % 16;
      step($urandom_range(0, 3) != 0, c);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    // 6: saturation of the narrow counter with ERR_LIMIT=1
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    c = 0;
    step(1, c);
    for (int i = 0; i < 10; i++) begin
      c = (c + 4) % 16;
      step(1, c);
      chk("t6.b_err",    32'(ifb.err),    32'd1);
      chk("t6.b_locked", 32'(ifb.locked), 32'd0);
    end
    chk("t6.b_err_count", 32'(ifb.err_count), 32'd3);
    chk("t6.a_err_count", 32'(ifa.err_count), 32'd10);

    step(0, c);
    @(negedge clk);
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
